dmem_ctrl: RTL

- Data-memory controller sitting between the MEM pipeline stage and the single-port, word-wide DMEM.
- Arbitrates DMEM between the CPU (MEM stage) and an external port (loader/debug) using CPU priority with a starvation guard.
- Sequences byte stores as read-modify-write and formats byte loads (signed/unsigned).
- Stalls the pipeline while the CPU request cannot be accepted.

---
 rtl/dmem_ctrl_if.sv | 40 ++++
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// CPU and external-port request/response bundle for the data-memory controller.
//   master: the requesters (MEM stage and loader/debug port)
//   slave : dmem_ctrl
// CPU side: cpu_req_{valid,we,byte,signed,addr,wdata} in, cpu_stall/cpu_rdata/cpu_rdata_valid out.
// EXT side: ext_req_{valid,we,addr,wdata} in, ext_req_ready/ext_rsp_valid/ext_rsp_data out.
interface dmem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  cpu_req_valid;
  logic                  cpu_req_we;
  logic                  cpu_req_byte;
  logic                  cpu_req_signed;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic [15:0]           cpu_req_wdata;
  logic                  cpu_stall;
  logic [15:0]           cpu_rdata;
  logic                  cpu_rdata_valid;

  logic                  ext_req_valid;
  logic                  ext_req_ready;
  logic                  ext_req_we;
  logic [ADDR_WIDTH-1:0] ext_req_addr;
  logic [15:0]           ext_req_wdata;
  logic                  ext_rsp_valid;
  logic [15:0]           ext_rsp_data;

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_byte, cpu_req_signed, cpu_req_addr, cpu_req_wdata,
    input  cpu_stall, cpu_rdata, cpu_rdata_valid,
    output ext_req_valid, ext_req_we, ext_req_addr, ext_req_wdata,
    input  ext_req_ready, ext_rsp_valid, ext_rsp_data
  );

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_byte, cpu_req_signed, cpu_req_addr, cpu_req_wdata,
    output cpu_stall, cpu_rdata, cpu_rdata_valid,
    input  ext_req_valid, ext_req_we, ext_req_addr, ext_req_wdata,
    output ext_req_ready, ext_rsp_valid, ext_rsp_data
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the MEM stage and a single-port word-wide DMEM.
// Arbitrates CPU vs external port (CPU priority, starvation guard), performs
// byte stores as read-modify-write and formats byte loads.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   bus            : CPU / external request+response bundle (dmem_ctrl_if.slave)
//   dmem_addr      : DMEM word index
//   dmem_wr_word   : DMEM write data
//   dmem_write_en  : DMEM write strobe
//   dmem_rd_word   : DMEM read data, valid one cycle after dmem_addr
module dmem_ctrl #(
  parameter int unsigned DMEM_ADDR_WIDTH  = 12,
  parameter int unsigned DMEM_WORD_WIDTH  = 16,
  parameter int unsigned STARVE_LIMIT     = 4,
  parameter int unsigned STARVE_CNT_WIDTH = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  dmem_ctrl_if.slave                 bus,
  output logic [DMEM_ADDR_WIDTH-2:0] dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] dmem_wr_word,
  output logic                       dmem_write_en,
  input  logic [DMEM_WORD_WIDTH-1:0] dmem_rd_word
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD, RMW} state_t;

  state_t                      state;
  logic                        owner_ext;
  logic [DMEM_ADDR_WIDTH-1:0]  addr_q;
  logic                        byte_q;
  logic                        signed_q;
  logic [7:0]                  wdata_q;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt;

  logic                       ext_win, cpu_grant, ext_grant, grant;
  logic                       sel_we, sel_byte, sel_signed;
  logic [DMEM_ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]                sel_wdata;
  logic [7:0]                 rd_byte;
  logic [15:0]                load_word, merged_word;

  // Arbitration and request selection; only meaningful in IDLE.
  always_comb begin
    ext_win   = bus.ext_req_valid && (!bus.cpu_req_valid || starve_cnt == LIMIT);
    cpu_grant = (state == IDLE) && bus.cpu_req_valid && !ext_win;
    ext_grant = (state == IDLE) && ext_win;
    grant     = cpu_grant || ext_grant;
    if (ext_win) begin
      sel_we     = bus.ext_req_we;
      sel_byte   = 1'b0;
      sel_signed = 1'b0;
      sel_addr   = bus.ext_req_addr;
      sel_wdata  = bus.ext_req_wdata;
    end else begin
      sel_we     = bus.cpu_req_we;
      sel_byte   = bus.cpu_req_byte;
      sel_signed = bus.cpu_req_signed;
      sel_addr   = bus.cpu_req_addr;
      sel_wdata  = bus.cpu_req_wdata;
    end
  end

  // Little-endian byte formatting of the returned word and RMW merge.
  always_comb begin
    rd_byte     = addr_q[0] ? dmem_rd_word[15:8] : dmem_rd_word[7:0];
    load_word   = byte_q ? {(signed_q ? {8{rd_byte[7]}} : 8'h00), rd_byte} : dmem_rd_word;
    merged_word = addr_q[0] ? {wdata_q, dmem_rd_word[7:0]} : {dmem_rd_word[15:8], wdata_q};
  end

  // Grant-cycle outputs must be combinational (DMEM address and word-store
  // strobe go out in the accept cycle); reset forces every output low.
  always_comb begin
    bus.cpu_stall       = 1'b0;
    bus.cpu_rdata       = '0;
    bus.cpu_rdata_valid = 1'b0;
    bus.ext_req_ready   = 1'b0;
    bus.ext_rsp_valid   = 1'b0;
    bus.ext_rsp_data    = '0;
    dmem_addr           = '0;
    dmem_wr_word        = '0;
    dmem_write_en       = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          bus.cpu_stall     = bus.cpu_req_valid && !cpu_grant;
          bus.ext_req_ready = ext_grant;
          if (grant) begin
            dmem_addr     = sel_addr[DMEM_ADDR_WIDTH-1:1];
            dmem_write_en = sel_we && !sel_byte;
            if (sel_we && !sel_byte) dmem_wr_word = sel_wdata;
          end
        end
        RD: begin
          bus.cpu_stall = bus.cpu_req_valid;
          dmem_addr     = addr_q[DMEM_ADDR_WIDTH-1:1];
          if (owner_ext) begin
            bus.ext_rsp_valid = 1'b1;
            bus.ext_rsp_data  = dmem_rd_word;
          end else begin
            bus.cpu_rdata_valid = 1'b1;
            bus.cpu_rdata       = load_word;
          end
        end
        RMW: begin
          bus.cpu_stall = bus.cpu_req_valid;
          dmem_addr     = addr_q[DMEM_ADDR_WIDTH-1:1];
          dmem_wr_word  = merged_word;
          dmem_write_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_ext  <= 1'b0;
      addr_q     <= '0;
      byte_q     <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.ext_req_valid || ext_grant) starve_cnt <= '0;
          else if (starve_cnt != LIMIT)        starve_cnt <= starve_cnt + 1'b1;
          // Word stores complete in the grant cycle; loads and byte stores
          // need a second cycle and capture the request here.
          if (grant && (!sel_we || sel_byte)) begin
            owner_ext <= ext_grant;
            addr_q    <= sel_addr;
            byte_q    <= sel_byte;
            signed_q  <= sel_signed;
            wdata_q   <= sel_wdata[7:0];
            state     <= sel_we ? RMW : RD;
          end
        end
        RD, RMW: begin
          if (!bus.ext_req_valid) starve_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
